mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the word-wide data RAM port (async read, sync write, no byte enables). Sits between the MEM pipeline stage and the data RAM.
- Accepts byte/half/word loads and stores from the pipeline.
- Converts sub-word stores into a two-cycle read-modify-write.
- Sign/zero-extends loads and returns a registered response.

Parameters:
ADDR_WIDTH, 5, word-address width of the attached RAM; byte address is ADDR_WIDTH+2 bits
DATA_WIDTH, 32, RAM word width; fixed at 32 (4 little-endian byte lanes)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline request valid
req_ready  out  1  unit can accept a request this cycle
req_write  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
req_addr  in  ADDR_WIDTH+2  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal size; qualified by rsp_valid
mem_write  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM word address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM async read data

Behaviour:
- Handshake: accept when req_valid && req_ready. req_ready = (state==IDLE). Requests are never queued.
- Lanes: word addr = req_addr[ADDR_WIDTH+1:2]. Lane = req_addr[1:0]; lane 0 = bits 7:0 (little-endian). Half uses lane 0 or 2.
- Misalignment:
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - size 11 is an error.
  - Error requests: accepted in 1 cycle, no RAM write; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- FSM states: IDLE, RMW_WR.
- IDLE:
  - mem_addr = req word addr.
  - mem_wdata = req_wdata.
  - mem_write = req_valid && req_write && size==word && aligned. Write commits at that edge; rsp_valid next cycle.
- Load accepted in IDLE:
  - Select lane from mem_rdata, extend per req_size/req_unsigned, register into rsp_rdata.
  - rsp_valid=1 on the next cycle. Latency 1.
- Sub-word store accepted in IDLE:
  - Register word addr and merged word (mem_rdata with target lane(s) replaced by req_wdata[7:0] or [15:0]).
  - Go to RMW_WR.
  - Merge is registered, never written in the accept cycle; this keeps the read->merge->write path out of one cycle.
- RMW_WR:
  - req_ready=0.
  - mem_write=1, mem_addr=latched addr, mem_wdata=merged reg.
  - Return to IDLE.
  - rsp_valid=1 on the following cycle. Store latency 2.
- Outputs in RMW_WR:
  - mem_addr/mem_wdata come from the latched registers.
  - Pipeline request inputs are ignored.
- rsp_valid: exactly one cycle per accepted request. rsp_err=0 except on the error case.
- Back-to-back: a request may be accepted in the same cycle rsp_valid is high for the previous one.
- Load after sub-word store to the same word: not accepted until IDLE, so it returns the merged value.
- Reset (async, rst_n low):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; merge/addr registers=0.
  - mem_write forced 0 while rst_n low.
  - Reset during RMW_WR aborts the write; the RAM word stays unchanged and no response is issued.

Decomposition:
- mem_pkg:
  - mem_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL).
  - mau_state_t enum (IDLE, RMW_WR).
  - Lane constants.
- Sub-module mem_lane_align (combinational):
  - Store merge: old word, wdata, lane, size -> merged word.
  - Load extract/extend: word, lane, size, unsigned -> rdata.
  - Reused by both paths; unit-testable alone.

Test Plan:
- Word store 0xDEADBEEF @0x08, then lw @0x08 -> mem_write 1 cycle at word 2; load rsp_rdata=0xDEADBEEF, rsp_err=0, latency 1.
- Word 2 preloaded 0x11223344; sb 0xAA @0x09 -> req_ready low 1 cycle, RAM word=0x1122AA44, rsp_valid 2 cycles after accept.
- Word 2 = 0x8000F0FF; lb @0x08 -> 0xFFFFFFFF; lbu @0x08 -> 0x000000FF; lh @0x0A -> 0xFFFF8000; lhu @0x0A -> 0x00008000.
- lw @0x0A; sh @0x09; req_size=11 -> each: no mem_write, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- sh 0xBEEF @0x0E then lw @0x0C back-to-back with req_valid held -> load waits for IDLE, returns word with [31:16]=0xBEEF.
- Assert rst_n low in RMW_WR of an sb -> mem_write=0 immediately, RAM word unchanged, no rsp_valid after release, req_ready=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and lane geometry for the data-RAM access unit.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int LANE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_t;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } mau_state_t;

    // Illegal size and misaligned half/word accesses are all reported as errors.
    function automatic logic is_req_err(mem_size_t size, logic [1:0] lane);
        case (size)
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != 2'b00);
            SZ_ILL:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane merge for sub-word stores and lane extract/extend for loads.
// Latency: combinational. Backpressure: none, pure function of inputs.
// Lane 0 is bits 7:0; half accesses use lane 0 or 2 (lane[1] picks the half).
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        lane,
    input  mem_size_t         size,
    input  logic              is_unsigned,
    output logic [WORD_W-1:0] merged,
    output logic [WORD_W-1:0] rdata
);

    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [WORD_W-1:0] shifted;

    assign byte_sh = {lane, 3'b000};
    assign half_sh = {lane[1], 4'b0000};
    assign shifted = old_word >> byte_sh;

    always_comb begin
        merged = old_word;
        rdata  = '0;
        case (size)
            SZ_BYTE: begin
                merged[byte_sh +: LANE_W] = wdata[LANE_W-1:0];
                rdata = {{(WORD_W-LANE_W){~is_unsigned & shifted[LANE_W-1]}},
                         shifted[LANE_W-1:0]};
            end
            SZ_HALF: begin
                merged[half_sh +: HALF_W] = wdata[HALF_W-1:0];
                rdata = {{(WORD_W-HALF_W){~is_unsigned & shifted[HALF_W-1]}},
                         shifted[HALF_W-1:0]};
            end
            SZ_WORD: begin
                merged = wdata;
                rdata  = old_word;
            end
            default: begin
                merged = old_word;
                rdata  = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline-to-data-RAM initiator: loads, word stores, sub-word stores via read-modify-write.
// Latency: loads, word stores and errors respond 1 cycle after accept; sub-word stores 2.
// Backpressure: req_ready drops for the single RMW write cycle; nothing is queued.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    mau_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] merge_q;
    logic                  rsp_valid_q, rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    mem_size_t             size;
    logic [1:0]            lane;
    logic [ADDR_WIDTH-1:0] req_word;
    logic                  req_err;
    logic                  accept;
    logic                  subword_st;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] extracted;

    assign size       = mem_size_t'(req_size);
    assign lane       = req_addr[1:0];
    assign req_word   = req_addr[ADDR_WIDTH+1:2];
    assign req_err    = is_req_err(size, lane);
    assign req_ready  = (state_q == IDLE);
    assign accept     = req_valid && req_ready;
    assign subword_st = req_write && !req_err && (size != SZ_WORD);

    mem_lane_align u_align (
        .old_word    (mem_rdata),
        .wdata       (req_wdata),
        .lane        (lane),
        .size        (size),
        .is_unsigned (req_unsigned),
        .merged      (merged),
        .rdata       (extracted)
    );

    always_comb begin
        state_d   = state_q;
        mem_write = 1'b0;
        mem_addr  = req_word;
        mem_wdata = req_wdata;
        case (state_q)
            IDLE: begin
                mem_write = req_valid && req_write && (size == SZ_WORD) && !req_err;
                if (accept && subword_st) begin
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merge_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset must kill an in-flight RMW write immediately, not at the next edge.
        if (!rst_n) begin
            mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            merge_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            if (state_q == RMW_WR) begin
                rsp_valid_q <= 1'b1;
            end else if (accept) begin
                if (subword_st) begin
                    addr_q  <= req_word;
                    merge_q <= merged;
                end else begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= req_err;
                    if (!req_write && !req_err) begin
                        rsp_rdata_q <= extracted;
                    end
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases then randomized traffic
// against a word-array reference model, with a behavioural RAM attached.
module tb_mem_access_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]    req_size;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    logic [31:0] ram     [32];
    logic [31:0] ref_mem [32];

    int n_cmp = 0;
    int n_err = 0;

    logic        pend = 1'b0;
    logic [31:0] pend_rdata;
    logic        pend_err;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_err(input int sz, input int addr);
        return (sz == 3) || (sz == 1 && (addr % 2) != 0) || (sz == 2 && (addr % 4) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input int lane, input int sz, input logic uns);
        longint v;
        longint word_v;
        word_v = longint'(w);
        if (sz == 0) begin
            v = (word_v >> (8 * lane)) & 255;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 1) begin
            v = (word_v >> (8 * lane)) & 65535;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = word_v;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] wd, input int lane, input int sz);
        logic [31:0] mask;
        mask = (sz == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
        return (w & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
    endfunction

    task automatic check_pending();
        if (pend) begin
            check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("rsp_err", {31'b0, rsp_err}, {31'b0, pend_err});
            check("rsp_rdata", rsp_rdata, pend_rdata);
            pend = 1'b0;
        end else begin
            check("rsp_idle", {31'b0, rsp_valid}, 32'd0);
        end
    endtask

    task automatic drive_garbage(input logic vld);
        req_valid    = vld;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = 7'($urandom);
        req_wdata    = $urandom;
    endtask

    task automatic idle();
        @(negedge clk);
        check_pending();
        drive_garbage(1'b0);
    endtask

    task automatic xact(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [6:0] addr, input logic [31:0] wd);
        int          widx, lane, s;
        logic        err, exp_mw, rmw;
        logic [31:0] mrg;
        widx = int'(addr) / 4;
        lane = int'(addr) % 4;
        s    = int'(sz);
        err  = m_err(s, int'(addr));
        @(negedge clk);
        check_pending();
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        #1;
        exp_mw = wr && (s == 2) && !err;
        rmw    = wr && !err && (s != 2);
        check("mem_write_acc", {31'b0, mem_write}, {31'b0, exp_mw});
        if (exp_mw) begin
            check("mem_addr_sw", {27'b0, mem_addr}, 32'(widx));
            check("mem_wdata_sw", mem_wdata, wd);
        end
        @(posedge clk);
        if (rmw) begin
            mrg = m_merge(ref_mem[widx], wd, lane, s);
            @(negedge clk);
            check("ready_rmw", {31'b0, req_ready}, 32'd0);
            check("rsp_in_rmw", {31'b0, rsp_valid}, 32'd0);
            drive_garbage(1'b1);
            #1;
            check("mem_write_rmw", {31'b0, mem_write}, 32'd1);
            check("mem_addr_rmw", {27'b0, mem_addr}, 32'(widx));
            check("mem_wdata_rmw", mem_wdata, mrg);
            @(posedge clk);
            ref_mem[widx] = mrg;
        end else if (exp_mw) begin
            ref_mem[widx] = wd;
        end
        pend       = 1'b1;
        pend_err   = err;
        pend_rdata = (!wr && !err) ? m_load(ref_mem[widx], lane, s, uns) : 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_garbage(1'b0);
        #12;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 7'h00;
        #1;
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) xact(1'b1, 2'b10, 1'b0, 7'(i * 4), $urandom);

        // word store / load
        xact(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEAD_BEEF);
        xact(1'b0, 2'b10, 1'b0, 7'h08, 32'h0);
        // byte RMW
        xact(1'b1, 2'b10, 1'b0, 7'h08, 32'h1122_3344);
        xact(1'b1, 2'b00, 1'b0, 7'h09, 32'h0000_00AA);
        idle();
        check("sb_ram", ram[2], 32'h1122_AA44);
        // extension
        xact(1'b1, 2'b10, 1'b0, 7'h08, 32'h8000_F0FF);
        xact(1'b0, 2'b00, 1'b0, 7'h08, 32'h0);
        xact(1'b0, 2'b00, 1'b1, 7'h08, 32'h0);
        xact(1'b0, 2'b01, 1'b0, 7'h0A, 32'h0);
        xact(1'b0, 2'b01, 1'b1, 7'h0A, 32'h0);
        // errors
        xact(1'b0, 2'b10, 1'b0, 7'h0A, 32'h0);
        xact(1'b1, 2'b01, 1'b0, 7'h09, 32'h1234_5678);
        xact(1'b0, 2'b11, 1'b0, 7'h08, 32'h0);
        // half store followed directly by load of the same word
        xact(1'b1, 2'b01, 1'b0, 7'h0E, 32'h0000_BEEF);
        xact(1'b0, 2'b10, 1'b0, 7'h0C, 32'h0);
        idle();
        check("sh_ram_hi", {16'b0, ram[3][31:16]}, 32'h0000_BEEF);

        // reset in the middle of an RMW aborts the write
        @(negedge clk);
        check_pending();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 7'h11; req_wdata = ~ref_mem[4];
        @(posedge clk);
        @(negedge clk);
        #1;
        check("abort_pre_wr", {31'b0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_write", {31'b0, mem_write}, 32'd0);
        check("abort_rsp", {31'b0, rsp_valid}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        check("abort_ram", ram[4], ref_mem[4]);
        xact(1'b0, 2'b10, 1'b0, 7'h10, 32'h0);

        for (int i = 0; i < 300; i++) begin
            xact(1'($urandom), 2'($urandom), 1'($urandom), 7'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        idle();
        for (int i = 0; i < 32; i++) check("ram_final", ram[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
